// File: rtl/masked_add_sequencer.sv
// Bit-serial masked adder: one ISW-masked full-adder slice reused for WIDTH cycles per addition.
// Operand shares are never recombined; carry shares are refreshed by an internal Galois LFSR.
module masked_add_sequencer #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned NSHARES   = 3,
    parameter logic [31:0] LFSR_SEED = 32'h1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NSHARES*WIDTH-1:0]   a_sh,
    input  logic [NSHARES*WIDTH-1:0]   b_sh,
    input  logic [NSHARES-1:0]         cin_sh,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NSHARES*WIDTH-1:0]   sum_sh,
    output logic [NSHARES-1:0]         cout_sh,
    output logic                       busy,
    output logic [$clog2(WIDTH)-1:0]   bit_idx
);
    localparam int unsigned IdxW     = $clog2(WIDTH);
    localparam int unsigned P        = NSHARES * (NSHARES - 1) / 2;
    localparam logic [31:0] LfsrMask = 32'h80200003;
    localparam logic [31:0] Seed     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                        r_state;
    logic [NSHARES-1:0][WIDTH-1:0] r_a;
    logic [NSHARES-1:0][WIDTH-1:0] r_b;
    logic [NSHARES-1:0][WIDTH-1:0] r_sum;
    logic [NSHARES-1:0]            r_c;
    logic [NSHARES-1:0]            r_cout;
    logic [IdxW-1:0]               r_bit_idx;
    logic [31:0]                   r_lfsr;
    logic                          r_in_ready;
    logic                          r_out_valid;
    logic                          r_busy;

    logic [NSHARES-1:0] w_a_bit;
    logic [NSHARES-1:0] w_b_bit;
    logic [NSHARES-1:0] w_t;
    logic [NSHARES-1:0] w_s;
    logic [NSHARES-1:0] w_c_next;
    logic [31:0]        w_lfsr_next;

    // Pairs (i<j) take rnd bits in row-major order; r_ji is derived, never drawn.
    function automatic logic [NSHARES-1:0] isw(input logic [NSHARES-1:0] x,
                                               input logic [NSHARES-1:0] y,
                                               input logic [P-1:0]       rnd);
        logic [NSHARES-1:0][NSHARES-1:0] r;
        logic [NSHARES-1:0]              z;
        int                              k;
        r = '0;
        z = '0;
        k = 0;
        for (int i = 0; i < NSHARES; i++) begin
            for (int j = i + 1; j < NSHARES; j++) begin
                r[i][j] = rnd[k];
                r[j][i] = (rnd[k] ^ (x[i] & y[j])) ^ (x[j] & y[i]);
                k++;
            end
        end
        for (int i = 0; i < NSHARES; i++) begin
            z[i] = x[i] & y[i];
            for (int j = 0; j < NSHARES; j++) begin
                if (j != i) begin
                    z[i] = z[i] ^ r[i][j];
                end
            end
        end
        return z;
    endfunction

    always_comb begin
        w_a_bit     = '0;
        w_b_bit     = '0;
        w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LfsrMask : 32'h0);
        for (int j = 0; j < NSHARES; j++) begin
            w_a_bit[j] = r_a[j][r_bit_idx];
            w_b_bit[j] = r_b[j][r_bit_idx];
        end
        w_t      = w_a_bit ^ w_b_bit;
        w_s      = w_t ^ r_c;
        w_c_next = isw(w_a_bit, w_b_bit, r_lfsr[P-1:0]) ^ isw(r_c, w_t, r_lfsr[2*P-1:P]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_c         <= '0;
            r_cout      <= '0;
            r_bit_idx   <= '0;
            r_lfsr      <= Seed;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_next;
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a        <= a_sh;
                        r_b        <= b_sh;
                        r_c        <= cin_sh;
                        r_bit_idx  <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    for (int j = 0; j < NSHARES; j++) begin
                        r_sum[j][r_bit_idx] <= w_s[j];
                    end
                    r_c <= w_c_next;
                    if (r_bit_idx == IdxW'(WIDTH - 1)) begin
                        r_cout      <= w_c_next;
                        r_bit_idx   <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_bit_idx <= r_bit_idx + IdxW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign bit_idx   = r_bit_idx;
    assign sum_sh    = r_sum;
    assign cout_sh   = r_cout;

endmodule

// File: tb/tb_masked_add_sequencer.sv
// Bench for masked_add_sequencer: directed checks on a 64-bit/3-share instance plus
// randomized soaks on 2- and 4-share instances, all scored against plain arithmetic.
module tb_masked_add_sequencer;
    localparam int W    = 64;
    localparam int N    = 3;
    localparam int SW   = 8;
    localparam int NOPS = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           rst_s_n;
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic [N*W-1:0] a_sh;
    logic [N*W-1:0] b_sh;
    logic [N*W-1:0] sum_sh;
    logic [N-1:0]   cin_sh;
    logic [N-1:0]   cout_sh;
    logic [5:0]     bit_idx;

    int checks = 0;
    int errors = 0;

    masked_add_sequencer #(
        .WIDTH     (W),
        .NSHARES   (N),
        .LFSR_SEED (32'h1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sh      (a_sh),
        .b_sh      (b_sh),
        .cin_sh    (cin_sh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_sh    (sum_sh),
        .cout_sh   (cout_sh),
        .busy      (busy),
        .bit_idx   (bit_idx)
    );

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] unmask(input logic [N*W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) r = r ^ v[j*W +: W];
        return r;
    endfunction

    function automatic logic [N*W-1:0] split(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        logic [W-1:0]   acc;
        acc = v;
        r   = '0;
        for (int j = 1; j < N; j++) begin
            r[j*W +: W] = {$urandom, $urandom};
            acc         = acc ^ r[j*W +: W];
        end
        r[W-1:0] = acc;
        return r;
    endfunction

    function automatic logic [N-1:0] split_c(input logic c);
        logic [N-1:0] r;
        r    = N'($urandom);
        r[0] = r[0] ^ (^r) ^ c;
        return r;
    endfunction

    // Scoreboard: expectation pushed on every accepted operand set, popped on output handshake.
    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;
    exp_t         exp_q[$];
    exp_t         e_pop;
    logic [W:0]   m_full;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                m_full = {1'b0, unmask(a_sh)} + {1'b0, unmask(b_sh)} + {{W{1'b0}}, ^cin_sh};
                exp_q.push_back('{sum: m_full[W-1:0], cout: m_full[W]});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 65'(unmask(sum_sh)), 65'h1_0000_0000_0000_0000);
                end else begin
                    e_pop = exp_q.pop_front();
                    check("sb_sum", 65'(unmask(sum_sh)), 65'(e_pop.sum));
                    check("sb_cout", 65'(^cout_sh), 65'(e_pop.cout));
                end
            end
        end
    end

    task automatic send(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        input logic [N-1:0] c, input bit keep);
        int n;
        n        = 0;
        a_sh     = a;
        b_sh     = b;
        cin_sh   = c;
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        check("accept_ready", 65'(in_ready), 65'(1));
        tick();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 65'(in_ready), 65'(1));
        check({tag, "_out_valid"}, 65'(out_valid), 65'(0));
        check({tag, "_busy"}, 65'(busy), 65'(0));
        check({tag, "_bit_idx"}, 65'(bit_idx), 65'(0));
        check({tag, "_sum_zero"}, 65'(sum_sh == '0), 65'(1));
        check({tag, "_cout"}, 65'(cout_sh), 65'(0));
    endtask

    // Soak instances: 2 and 4 shares on a narrow datapath, random out_ready.
    for (genvar g = 0; g < 2; g++) begin : g_soak
        localparam int SN = (g == 0) ? 2 : 4;
        logic              s_in_valid;
        logic              s_in_ready;
        logic              s_out_valid;
        logic              s_out_ready;
        logic              s_busy;
        logic [SN*SW-1:0]  s_a;
        logic [SN*SW-1:0]  s_b;
        logic [SN*SW-1:0]  s_sum;
        logic [SN-1:0]     s_cin;
        logic [SN-1:0]     s_cout;
        logic [$clog2(SW)-1:0] s_idx;
        logic [SW:0]       s_q[$];
        logic [SW:0]       s_e;
        logic [SW-1:0]     s_ua;
        logic [SW-1:0]     s_ub;
        logic [SW-1:0]     s_us;
        bit                done_flag = 1'b0;

        masked_add_sequencer #(
            .WIDTH     (SW),
            .NSHARES   (SN),
            .LFSR_SEED (32'(32'hACE1 + g))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_s_n),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .a_sh      (s_a),
            .b_sh      (s_b),
            .cin_sh    (s_cin),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .sum_sh    (s_sum),
            .cout_sh   (s_cout),
            .busy      (s_busy),
            .bit_idx   (s_idx)
        );

        always @(posedge clk) begin
            #1;
            s_out_ready = ($urandom_range(0, 3) != 0);
        end

        always @(negedge clk) begin
            if (rst_s_n) begin
                if (s_in_valid && s_in_ready) begin
                    s_ua = '0;
                    s_ub = '0;
                    for (int j = 0; j < SN; j++) begin
                        s_ua = s_ua ^ s_a[j*SW +: SW];
                        s_ub = s_ub ^ s_b[j*SW +: SW];
                    end
                    s_q.push_back({1'b0, s_ua} + {1'b0, s_ub} + {{SW{1'b0}}, ^s_cin});
                end
                if (s_out_valid && s_out_ready) begin
                    s_us = '0;
                    for (int j = 0; j < SN; j++) s_us = s_us ^ s_sum[j*SW +: SW];
                    if (s_q.size() == 0) begin
                        check("soak_unexpected", 65'({^s_cout, s_us}), 65'h1_0000_0000_0000_0000);
                    end else begin
                        s_e = s_q.pop_front();
                        check("soak_result", 65'({^s_cout, s_us}), 65'(s_e));
                    end
                end
            end
        end

        initial begin
            logic [SW-1:0] va;
            logic [SW-1:0] vb;
            logic [SW-1:0] m;
            int            n;
            s_in_valid = 1'b0;
            s_a        = '0;
            s_b        = '0;
            s_cin      = '0;
            wait (rst_s_n === 1'b1);
            tick();
            for (int k = 0; k < NOPS; k++) begin
                va = ($urandom_range(0, 7) == 0) ? '1 : SW'($urandom);
                vb = SW'($urandom);
                for (int j = 1; j < SN; j++) begin
                    m = SW'($urandom);
                    s_a[j*SW +: SW] = m;
                    va = va ^ m;
                    m = SW'($urandom);
                    s_b[j*SW +: SW] = m;
                    vb = vb ^ m;
                end
                s_a[SW-1:0] = va;
                s_b[SW-1:0] = vb;
                s_cin       = SN'($urandom);
                s_in_valid  = 1'b1;
                n = 0;
                while (!s_in_ready && n < 200) begin
                    tick();
                    n++;
                end
                check("soak_accept", 65'(s_in_ready), 65'(1));
                tick();
                s_in_valid = 1'b0;
                if ($urandom_range(0, 3) == 0) tick();
            end
            n = 0;
            while (s_q.size() != 0 && n < 1000) begin
                tick();
                n++;
            end
            done_flag = 1'b1;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] av, bv, s1, s2, snap_s;
        logic [N-1:0]   cv, snap_c;
        logic [W-1:0]   va, vb;
        logic [W:0]     ref_full;
        int             n;

        rst_n     = 1'b0;
        rst_s_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_sh      = '0;
        b_sh      = '0;
        cin_sh    = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        tick();

        // 5 + 7 + 0
        out_ready = 1'b1;
        send(split(64'd5), split(64'd7), split_c(1'b0), 1'b0);
        check("t1_busy", 65'(busy), 65'(1));
        check("t1_in_ready_low", 65'(in_ready), 65'(0));
        wait_out(n);
        check("t1_latency", 65'(n), 65'(64));
        check("t1_sum", 65'(unmask(sum_sh)), 65'd12);
        check("t1_cout", 65'(^cout_sh), 65'(0));
        tick();
        check("t1_in_ready_back", 65'(in_ready), 65'(1));
        check("t1_out_valid_drop", 65'(out_valid), 65'(0));

        // full carry ripple
        send(split(64'hFFFF_FFFF_FFFF_FFFF), split(64'd0), split_c(1'b1), 1'b0);
        wait_out(n);
        check("t2_sum", 65'(unmask(sum_sh)), 65'd0);
        check("t2_cout", 65'(^cout_sh), 65'(1));
        tick();

        // backpressure with in_valid held high
        out_ready = 1'b0;
        av = split({$urandom, $urandom});
        bv = split({$urandom, $urandom});
        cv = split_c(1'($urandom));
        send(av, bv, cv, 1'b1);
        wait_out(n);
        check("bp_latency", 65'(n), 65'(64));
        snap_s = sum_sh;
        snap_c = cout_sh;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_sum_stable", 65'(sum_sh == snap_s), 65'(1));
            check("bp_cout_stable", 65'(cout_sh), 65'(snap_c));
            check("bp_in_ready", 65'(in_ready), 65'(0));
            check("bp_out_valid", 65'(out_valid), 65'(1));
        end
        out_ready = 1'b1;
        tick();
        check("bp_hs_in_ready", 65'(in_ready), 65'(1));
        check("bp_hs_out_valid", 65'(out_valid), 65'(0));
        check("bp_hs_busy", 65'(busy), 65'(0));
        tick();
        check("bp_second_accept", 65'(busy), 65'(1));
        in_valid = 1'b0;
        wait_out(n);
        tick();

        // mask freshness: identical shares twice
        va = {$urandom, $urandom};
        vb = {$urandom, $urandom};
        av = split(va);
        bv = split(vb);
        cv = split_c(1'b0);
        ref_full = {1'b0, va} + {1'b0, vb};
        send(av, bv, cv, 1'b0);
        wait_out(n);
        s1 = sum_sh;
        tick();
        send(av, bv, cv, 1'b0);
        wait_out(n);
        s2 = sum_sh;
        tick();
        check("fresh_sum1", 65'(unmask(s1)), 65'(ref_full[W-1:0]));
        check("fresh_sum2", 65'(unmask(s2)), 65'(ref_full[W-1:0]));
        check("fresh_shares_differ", 65'(s1 !== s2), 65'(1));

        // reset in the middle of RUN
        send(split({$urandom, $urandom}), split({$urandom, $urandom}), split_c(1'b1), 1'b0);
        n = 0;
        while (bit_idx != 6'd20 && n < 500) begin
            tick();
            n++;
        end
        check("rst_reach_idx20", 65'(bit_idx), 65'd20);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        send(split(64'd100), split(64'd23), split_c(1'b1), 1'b0);
        wait_out(n);
        check("rst_latency", 65'(n), 65'(64));
        check("rst_sum", 65'(unmask(sum_sh)), 65'd124);
        check("rst_cout", 65'(^cout_sh), 65'(0));
        tick();

        n = 0;
        while (!(g_soak[0].done_flag && g_soak[1].done_flag) && n < 90000) begin
            tick();
            n++;
        end
        check("soak_done", 65'(g_soak[0].done_flag && g_soak[1].done_flag), 65'(1));
        check("soak2_drained", 65'(g_soak[0].s_q.size()), 65'(0));
        check("soak4_drained", 65'(g_soak[1].s_q.size()), 65'(0));
        check("main_drained", 65'(exp_q.size()), 65'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
